// File: rtl/lr_shift_engine_if.sv
// Handshake and data bundle for the left/right shift engine.
// The master side drives requests; the slave side is the engine itself.
interface lr_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             load;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic             direction;
  logic [1:0]       mode;
  logic             d;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] out;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output load, pdata, start, direction, mode, d, amount,
    input  out, so, busy, done
  );

  modport slave (
    input  load, pdata, start, direction, mode, d, amount,
    output out, so, busy, done
  );
endinterface

// File: rtl/lr_shift_engine.sv
// Parametrised left/right shift engine with parallel load, logical/rotate/
// arithmetic modes and multi-cycle shifts by a captured amount.
// A request is accepted only in IDLE; the engine then spends amount+1 cycles
// in SHIFT (one step per cycle while the counter is non-zero, then one final
// cycle to return to IDLE) and pulses done for the cycle after.
module lr_shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  lr_shift_engine_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_next;
  logic             done_q;
  logic             done_next;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] out_q;
  logic             so_q;

  // request attributes frozen at start so input changes during SHIFT are harmless
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             d_q;

  // One 1-bit step: returns {ejected bit, new register value}.
  // Mode 11 is reserved and behaves as logical.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] val,
    input logic             dir,
    input logic [1:0]       md,
    input logic             fill_d
  );
    logic ejected;
    logic fill;
    ejected = dir ? val[0] : val[WIDTH-1];
    case (md)
      2'b01:   fill = ejected;
      2'b10:   fill = dir ? val[WIDTH-1] : 1'b0;
      default: fill = fill_d;
    endcase
    if (dir) begin
      return {ejected, fill, val[WIDTH-1:1]};
    end
    return {ejected, val[WIDTH-2:0], fill};
  endfunction

  // state register and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

  // next-state logic: load has priority over start in IDLE
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.load && bus.start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // shift register, ejected bit and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      so_q  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            out_q <= bus.pdata;
          end else if (bus.start) begin
            count <= bus.amount;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            {so_q, out_q} <= shift_step(out_q, dir_q, mode_q, d_q);
            count         <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // capture of request attributes; pure data, so no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && !bus.load && bus.start) begin
      dir_q  <= bus.direction;
      mode_q <= bus.mode;
      d_q    <= bus.d;
    end
  end

  assign bus.out  = out_q;
  assign bus.so   = so_q;
  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;

endmodule

// File: tb/tb_lr_shift_engine.sv
// Bench for lr_shift_engine: closed-form reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lr_shift_engine;
  localparam int W  = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lr_shift_engine_if #(.WIDTH(W), .AMT_W(AW)) bus ();
  lr_shift_engine #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [W-1:0] m_out;
  logic         m_so;
  logic         m_busy;
  logic         m_done;
  int           m_steps;
  int           m_amt;
  logic [W-1:0] m_orig;
  logic         m_dir;
  logic [1:0]   m_mode;
  logic         m_d;

  // Result of n (>=1) whole steps applied to v: {last ejected bit, value}.
  function automatic logic [W:0] closed(input logic [W-1:0] v, input logic dir,
                                        input logic [1:0] md, input logic dd, input int n);
    logic [W-1:0] ones;
    logic [W-1:0] r;
    logic         s;
    int           k;
    ones = '1;
    if (md == 2'b01) begin
      k = n % W;
      if (dir) begin
        r = (v >> k) | (v << (W - k));
        s = v[(n - 1) % W];
      end else begin
        r = (v << k) | (v >> (W - k));
        s = v[(W - k) % W];
      end
    end else if (md == 2'b10) begin
      if (dir) begin
        r = $signed(v) >>> n;
        s = (n <= W) ? v[n - 1] : v[W - 1];
      end else begin
        r = (n >= W) ? '0 : (v << n);
        s = (n <= W) ? v[W - n] : 1'b0;
      end
    end else begin
      if (dir) begin
        r = (n >= W) ? {W{dd}} : ((v >> n) | (dd ? ~(ones >> n) : '0));
        s = (n <= W) ? v[n - 1] : dd;
      end else begin
        r = (n >= W) ? {W{dd}} : ((v << n) | (dd ? ~(ones << n) : '0));
        s = (n <= W) ? v[W - n] : dd;
      end
    end
    return {s, r};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (reset) begin
        m_out = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          if (m_steps < m_amt) begin
            m_steps++;
            {m_so, m_out} = closed(m_orig, m_dir, m_mode, m_d, m_steps);
          end else begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end else if (bus.load) begin
          m_out = bus.pdata;
        end else if (bus.start) begin
          m_orig  = m_out;
          m_dir   = bus.direction;
          m_mode  = bus.mode;
          m_d     = bus.d;
          m_amt   = int'(bus.amount);
          m_steps = 0;
          m_busy  = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("out",  32'(bus.out),  32'(m_out));
        check("so",   32'(bus.so),   32'(m_so));
      end
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk);
    bus.load = 1'b1; bus.pdata = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_start(input logic dir, input logic [1:0] md, input logic dd, input logic [AW-1:0] amt);
    @(negedge clk);
    bus.start = 1'b1; bus.direction = dir; bus.mode = md; bus.d = dd; bus.amount = amt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is high; counts busy cycles seen on the way.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) return;
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    bus.load = 1'b0; bus.pdata = '0; bus.start = 1'b0; bus.direction = 1'b0;
    bus.mode = 2'b00; bus.d = 1'b0; bus.amount = '0;
    fork
      model_loop();
      compare_loop();
    join_none

    // model pinned to hand-computed results
    check("pin_left_logical", 32'(closed(8'hA5, 1'b0, 2'b00, 1'b1, 3)), 32'h12F);
    check("pin_right_rotate", 32'(closed(8'h81, 1'b1, 2'b01, 1'b0, 9)), 32'h1C0);
    check("pin_right_arith",  32'(closed(8'h90, 1'b1, 2'b10, 1'b0, 2)), 32'h0E4);
    check("pin_left_arith",   32'(closed(8'h90, 1'b0, 2'b10, 1'b0, 1)), 32'h120);
    check("pin_flush",        32'(closed(8'h5A, 1'b1, 2'b11, 1'b1, 12)), 32'h1FF);

    // reset held two cycles
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_so",  32'(bus.so), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    // reset in the middle of a shift
    do_load(8'h77);
    do_start(1'b0, 2'b00, 1'b1, 4'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out",  32'(bus.out), 32'h0);
    check("midrst_so",   32'(bus.so), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);

    // left logical, d=1, by 3
    do_load(8'hA5);
    do_start(1'b0, 2'b00, 1'b1, 4'd3);
    wait_done(nb);
    check("ll_out", 32'(bus.out), 32'h2F);
    check("ll_so", 32'(bus.so), 32'h1);
    check("ll_busy_cycles", 32'(nb), 32'd4);
    @(negedge clk);
    check("ll_done_one_cycle", 32'(bus.done), 32'h0);

    // right rotate by 9 (wraps)
    do_load(8'h81);
    do_start(1'b1, 2'b01, 1'b0, 4'd9);
    wait_done(nb);
    check("rr_out", 32'(bus.out), 32'hC0);
    check("rr_so", 32'(bus.so), 32'h1);
    check("rr_busy_cycles", 32'(nb), 32'd10);

    // arithmetic right and left
    do_load(8'h90);
    do_start(1'b1, 2'b10, 1'b0, 4'd2);
    wait_done(nb);
    check("ar_out", 32'(bus.out), 32'hE4);
    check("ar_so", 32'(bus.so), 32'h0);
    do_load(8'h90);
    do_start(1'b0, 2'b10, 1'b0, 4'd1);
    wait_done(nb);
    check("al_out", 32'(bus.out), 32'h20);
    check("al_so", 32'(bus.so), 32'h1);

    // amount=0 with a load pulsed during the single busy cycle
    do_load(8'h3C);
    @(negedge clk);
    bus.start = 1'b1; bus.amount = '0;
    @(negedge clk);
    bus.start = 1'b0; bus.load = 1'b1; bus.pdata = 8'hFF;
    check("zero_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    bus.load = 1'b0;
    check("zero_done", 32'(bus.done), 32'h1);
    check("zero_busy_low", 32'(bus.busy), 32'h0);
    check("zero_out", 32'(bus.out), 32'h3C);
    check("zero_so", 32'(bus.so), 32'h1);

    // load and start together: load wins
    @(negedge clk);
    bus.load = 1'b1; bus.start = 1'b1; bus.pdata = 8'h5A; bus.amount = 4'd2;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    check("ls_out", 32'(bus.out), 32'h5A);
    check("ls_busy", 32'(bus.busy), 32'h0);

    // back-to-back start in the done cycle
    do_start(1'b1, 2'b00, 1'b1, 4'd1);
    wait_done(nb);
    bus.start = 1'b1; bus.direction = 1'b0; bus.mode = 2'b00; bus.d = 1'b0; bus.amount = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'h1);
    wait_done(nb);
    check("b2b_out", 32'(bus.out), 32'hB4);
    check("b2b_so", 32'(bus.so), 32'h0);

    // randomized traffic, including requests during SHIFT and rare resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 299) == 0);
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.pdata     = W'($urandom);
      bus.direction = 1'($urandom);
      bus.mode      = 2'($urandom);
      bus.d         = 1'($urandom);
      bus.amount    = AW'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
